// File: rtl/vx_alu_req_arb_buf.sv
// Round-robin arbiter over NUM_REQS issue channels feeding a DEPTH-entry in-order FIFO
// that presents the oldest ALU request over a valid/ready handshake.
module vx_alu_req_arb_buf #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 256,
    parameter int DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NUM_REQS-1:0]           req_valid,
    input  logic [NUM_REQS*DATAW-1:0]     req_data,
    output logic [NUM_REQS-1:0]           req_ready,
    output logic                          out_valid,
    output logic [DATAW-1:0]              out_data,
    input  logic                          out_ready,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH+1);
    localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  grant;
    logic [IDXW:0]    cand_sum;
    logic [IDXW-1:0]  cand;
    logic             found;
    logic             pop;
    logic             push;
    logic             can_push;
    logic [DATAW-1:0] push_data;

    // Handshake: a transfer happens on an edge where valid and ready are both high;
    // a source holds valid and data until then, and valid never waits on ready.
    assign empty     = (count == '0);
    assign full      = (count == CNTW'(DEPTH));
    assign out_valid = !empty && !flush;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign can_push  = (!full || pop) && !flush && !reset;

    // Search starts at rr_ptr and wraps modulo NUM_REQS, which need not be a power of 2.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand_sum = {1'b0, rr_ptr} + (IDXW+1)'(i);
            if (cand_sum >= (IDXW+1)'(NUM_REQS)) begin
                cand_sum = cand_sum - (IDXW+1)'(NUM_REQS);
            end
            cand = cand_sum[IDXW-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && can_push) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign push      = |(req_valid & req_ready);
    assign push_data = req_data[grant*DATAW +: DATAW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // rr_ptr survives a flush so fairness carries across it.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant == IDXW'(NUM_REQS-1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_vx_alu_req_arb_buf.sv
// Directed bench for vx_alu_req_arb_buf: reset, single request, round-robin order,
// full with simultaneous push/pop, pointer wrap-around and flush.
module tb_vx_alu_req_arb_buf;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int DP = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic [2:0]        count;
    logic              full;
    logic              empty;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    vx_alu_req_arb_buf #(.NUM_REQS(NR), .DATAW(DW), .DEPTH(DP)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input int val);
        req_data[ch*DW +: DW] = DW'(val);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    // seq holds the expected grant indices, two bits each, first grant in the LSBs
    task automatic run_rr(input logic [3:0] vld, input int n, input logic [15:0] seq);
        logic [3:0] oh;
        logic [1:0] g;
        do_reset();
        for (int i = 0; i < NR; i++) set_ch(i, i);
        req_valid = vld;
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            g  = seq[2*k +: 2];
            oh = 4'b0001 << g;
            check("rr_grant", 32'(req_ready), 32'(oh));
            if (out_valid) begin
                if (exp_q.size() > 0) check("rr_data", 32'(out_data), 32'(exp_q.pop_front()));
                else check("rr_spurious_valid", 32'(out_valid), 32'd0);
            end
            exp_q.push_back(DW'(g));
            step();
        end
        req_valid = '0;
        #1;
        check("rr_last_data", 32'(out_data), 32'(exp_q.pop_front()));
    endtask

    int nxt;
    int popped;
    int max_cnt;

    initial begin
        // reset state, with requests pending so req_ready must be suppressed
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        req_valid = 4'b1111;
        req_data  = '0;
        @(posedge clk);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        reset     = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'b0001);

        // single request on channel 2
        req_valid = 4'b0100;
        set_ch(2, 'hA5);
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        #1;
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'hA5);
        check("single_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        check("single_drained", 32'(empty), 32'd1);

        // round-robin order
        run_rr(4'b1111, 6, 16'({2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0}));
        run_rr(4'b1010, 4, 16'({2'd3, 2'd1, 2'd3, 2'd1}));

        // asynchronous reset with three entries buffered
        do_reset();
        req_valid = 4'b0001;
        set_ch(0, 'h11);
        repeat (3) step();
        req_valid = 4'b1111;
        #1;
        check("mid_count_before", 32'(count), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        reset     = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("mid_rel_req_ready", 32'(req_ready), 32'b0001);

        // fill to DEPTH, then push and pop together while full
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < DP; k++) begin
            set_ch(0, 10 + k);
            step();
        end
        set_ch(0, 14);
        #1;
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd4);
        check("full_req_ready", 32'(req_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("full_pp_ready", 32'(req_ready), 32'b0001);
        check("full_head", 32'(out_data), 32'd10);
        step();
        req_valid = '0;
        #1;
        check("full_pp_count", 32'(count), 32'd4);
        for (int v = 11; v <= 14; v++) begin
            check("full_drain_data", 32'(out_data), 32'(v));
            step();
        end
        check("full_drain_empty", 32'(empty), 32'd1);
        out_ready = 1'b0;

        // wrap-around: data 1..10 with random back-pressure
        do_reset();
        nxt     = 1;
        popped  = 0;
        max_cnt = 0;
        for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            req_valid = (nxt <= 10) ? 4'b0001 : 4'b0000;
            set_ch(0, nxt);
            #1;
            if (int'(count) > max_cnt) max_cnt = int'(count);
            check("wrap_count", 32'(count), 32'(exp_q.size()));
            check("wrap_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("wrap_data", 32'(out_data), 32'(exp_q.pop_front()));
                popped++;
            end
            if (req_ready[0]) begin
                exp_q.push_back(DW'(nxt));
                nxt++;
            end
            step();
        end
        check("wrap_popped", 32'(popped), 32'd10);
        check("wrap_max_le_depth", 32'(max_cnt <= DP), 32'd1);
        out_ready = 1'b0;
        req_valid = '0;

        // flush with three entries; rr_ptr must survive
        do_reset();
        for (int i = 0; i < NR; i++) set_ch(i, i);
        req_valid = 4'b1111;
        repeat (3) step();
        flush = 1'b1;
        #1;
        check("flush_pre_count", 32'(count), 32'd3);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_req_ready", 32'(req_ready), 32'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush_count", 32'(count), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_rr_resume", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        #1;
        check("flush_first_data", 32'(out_data), 32'd3);
        check("flush_first_count", 32'(count), 32'd1);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
